fft_bfly_s1: RTL

Stage-1 radix-2 single-path delay-feedback (SDF) butterfly of the 32-point pipelined FFT. It accepts one complex 11-bit sample per valid cycle and holds the first half-frame in a 16-deep feedback delay line. It then emits the 16 sums followed by the 16 differences as 12-bit samples. Its output drives the stage-1 twiddle multiplier directly, and `out_valid` is wired to that multiplier's `cnt_en`.

---
 rtl/fft_bfly_s1_if.sv | 32 +++
 rtl/fft_bfly_s1.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_s1_if.sv
// rtl/fft_bfly_s1_if.sv - sample-in / sample-out stream bundle for the stage-1 SDF butterfly
//
// Signals (directions given for the butterfly, i.e. the slave modport):
//   in_valid   in   input sample presented
//   in_ready   out  butterfly accepts a sample this cycle
//   in_real    in   DW-bit signed real part, s0.10
//   in_imag    in   DW-bit signed imaginary part, s0.10
//   out_valid  out  output sample valid (twiddle multiplier cnt_en)
//   out_real   out  DW+1-bit signed real part, s1.10
//   out_imag   out  DW+1-bit signed imaginary part, s1.10
// master: the environment side that drives samples and consumes results.
interface fft_bfly_s1_if #(
    parameter int DW = 11
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_valid;
    logic signed [DW:0]   out_real;
    logic signed [DW:0]   out_imag;

    modport slave (
        input  in_valid, in_real, in_imag,
        output in_ready, out_valid, out_real, out_imag
    );

    modport master (
        output in_valid, in_real, in_imag,
        input  in_ready, out_valid, out_real, out_imag
    );
endinterface

// File: rtl/fft_bfly_s1.sv
// rtl/fft_bfly_s1.sv - stage-1 radix-2 SDF butterfly of the 32-point pipelined FFT
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  fft_bfly_s1_if.slave: in_valid/in_ready/in_real/in_imag sample input,
//        out_valid/out_real/out_imag registered sum/difference output
// A frame of N samples yields N/2 sums x[n]+x[n+N/2] followed by N/2
// differences x[n]-x[n+N/2]. The differences of one frame leave while the
// first half of the next frame is loaded, or in DRAIN if the stream stops.
module fft_bfly_s1 #(
    parameter int N  = 32,
    parameter int DW = 11
) (
    input  logic           clk,
    input  logic           rst,
    fft_bfly_s1_if.slave   bus
);
    localparam int HALF = N / 2;
    localparam int CW   = $clog2(N);
    localparam int W    = DW + 1;

    typedef enum logic [1:0] {IDLE, HALF1, HALF2, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        icnt, icnt_nxt;
    logic                 pending, pending_nxt;
    logic                 rdy_nxt;
    logic                 ov_nxt;
    logic signed [W-1:0]  ore_nxt, oim_nxt;

    // Feedback delay line: entry 0 is the head (oldest), pushes enter at HALF-1.
    logic signed [W-1:0]  dl_re [HALF];
    logic signed [W-1:0]  dl_im [HALF];
    logic                 shift;
    logic signed [W-1:0]  push_re, push_im;

    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic                 acc;

    assign a_re = dl_re[0];
    assign a_im = dl_im[0];
    assign b_re = {bus.in_real[DW-1], bus.in_real};
    assign b_im = {bus.in_imag[DW-1], bus.in_imag};
    assign acc  = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            icnt         <= '0;
            pending      <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_real <= '0;
            bus.out_imag <= '0;
        end else begin
            state        <= state_nxt;
            icnt         <= icnt_nxt;
            pending      <= pending_nxt;
            bus.in_ready <= rdy_nxt;
            bus.out_valid <= ov_nxt;
            bus.out_real <= ore_nxt;
            bus.out_imag <= oim_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HALF; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else if (shift) begin
            for (int i = 0; i < HALF - 1; i++) begin
                dl_re[i] <= dl_re[i+1];
                dl_im[i] <= dl_im[i+1];
            end
            dl_re[HALF-1] <= push_re;
            dl_im[HALF-1] <= push_im;
        end
    end

    always_comb begin
        state_nxt   = state;
        icnt_nxt    = icnt;
        pending_nxt = pending;
        rdy_nxt     = 1'b1;
        ov_nxt      = 1'b0;
        ore_nxt     = bus.out_real;
        oim_nxt     = bus.out_imag;
        shift       = 1'b0;
        push_re     = b_re;
        push_im     = b_im;

        case (state)
            IDLE: begin
                if (acc) begin
                    shift     = 1'b1;
                    icnt_nxt  = CW'(1);
                    state_nxt = HALF1;
                end
            end

            HALF1: begin
                if (icnt == '0 && pending && !bus.in_valid) begin
                    // Stream ended at a frame boundary: the first difference
                    // is popped on this very cycle so the output stays
                    // gap-free into DRAIN.
                    shift     = 1'b1;
                    push_re   = '0;
                    push_im   = '0;
                    ov_nxt    = 1'b1;
                    ore_nxt   = a_re;
                    oim_nxt   = a_im;
                    icnt_nxt  = CW'(1);
                    rdy_nxt   = 1'b0;
                    state_nxt = DRAIN;
                end else if (acc) begin
                    shift    = 1'b1;
                    icnt_nxt = icnt + CW'(1);
                    if (pending) begin
                        ov_nxt  = 1'b1;
                        ore_nxt = a_re;
                        oim_nxt = a_im;
                    end
                    if (icnt == CW'(HALF - 1)) begin
                        state_nxt   = HALF2;
                        pending_nxt = 1'b0;
                    end
                end
            end

            HALF2: begin
                if (acc) begin
                    shift    = 1'b1;
                    push_re  = a_re - b_re;
                    push_im  = a_im - b_im;
                    ov_nxt   = 1'b1;
                    ore_nxt  = a_re + b_re;
                    oim_nxt  = a_im + b_im;
                    icnt_nxt = icnt + CW'(1);
                    if (icnt == CW'(N - 1)) begin
                        state_nxt   = HALF1;
                        pending_nxt = 1'b1;
                    end
                end
            end

            DRAIN: begin
                // icnt counts the DRAIN cycles 1..HALF; the last one only
                // retires the final output and reopens the input.
                if (icnt == CW'(HALF)) begin
                    icnt_nxt    = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    rdy_nxt  = 1'b0;
                    shift    = 1'b1;
                    push_re  = '0;
                    push_im  = '0;
                    ov_nxt   = 1'b1;
                    ore_nxt  = a_re;
                    oim_nxt  = a_im;
                    icnt_nxt = icnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
